// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared opcode constants, SYSCALL decode and fetch FSM state type
package cpu_defs_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNC_SYSCALL = 6'b001100;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_VALID = 2'd2,
        FS_HALT  = 2'd3
    } fetch_state_t;

    function automatic logic is_syscall(input logic [31:0] word);
        return (word[31:26] == OP_RTYPE) && (word[5:0] == FUNC_SYSCALL);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and decoder handshake bundle of the fetch stage
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic        inst_valid;
    logic        inst_ready;
    logic [5:0]  inst_opcode;
    logic [5:0]  inst_func;
    logic [31:0] inst_word;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        take_branch;
    logic        take_jump;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst_valid, inst_opcode, inst_func, inst_word, pc, pc_plus4,
        input  inst_ready, take_branch, take_jump
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst_valid, inst_opcode, inst_func, inst_word, pc, pc_plus4,
        output inst_ready, take_branch, take_jump
    );

endinterface

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection (jump, branch, sequential)
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic        take_jump,
    input  logic        take_branch,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        unused_ir_opcode;

    // All sums are modulo 2^32 so the top of the address space wraps to 0
    assign pc_plus4      = pc + 32'd4;
    assign branch_offset = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_offset;
    assign jump_target   = {pc_plus4[31:28], ir[25:0], 2'b00};

    // The opcode field is decoded upstream of this block
    assign unused_ir_opcode = ^ir[31:26];

    // Jump outranks branch, branch outranks fall-through
    always_comb begin
        next_pc = pc_plus4;
        if (take_jump) begin
            next_pc = jump_target;
        end else if (take_branch) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - multicycle instruction fetch: PC, IR, fetch FSM and retire counter
module fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_b,
    fetch_unit_if.master  fif,
    output logic          halted,
    output logic [31:0]   inst_count
);

    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [31:0] ir;
    logic [31:0] pc_q;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic        fetch_done;
    logic        retire;
    logic        ir_syscall;

    assign fetch_done = (state == FS_FETCH) && fif.imem_ack;
    assign retire     = (state == FS_VALID) && fif.inst_ready;
    assign ir_syscall = is_syscall(ir);

    next_pc_calc u_next_pc (
        .pc          (pc_q),
        .ir          (ir),
        .take_jump   (fif.take_jump),
        .take_branch (fif.take_branch),
        .next_pc     (next_pc),
        .pc_plus4    (pc_plus4)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= FS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM transitions; HALT is absorbing until reset
    always_comb begin
        state_nxt = state;
        case (state)
            FS_IDLE:  state_nxt = FS_FETCH;
            FS_FETCH: if (fif.imem_ack) state_nxt = FS_VALID;
            FS_VALID: if (fif.inst_ready) state_nxt = ir_syscall ? FS_HALT : FS_FETCH;
            FS_HALT:  state_nxt = FS_HALT;
            default:  state_nxt = FS_IDLE;
        endcase
    end

    // FSM outputs decoded straight from state so reset drops the request at once
    always_comb begin
        fif.imem_req   = 1'b0;
        fif.inst_valid = 1'b0;
        halted         = 1'b0;
        case (state)
            FS_FETCH: fif.imem_req   = 1'b1;
            FS_VALID: fif.inst_valid = 1'b1;
            FS_HALT:  halted         = 1'b1;
            default:  ;
        endcase
    end

    // IR capture on ack, PC advance and retire count on ready
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ir         <= 32'd0;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            inst_count <= 32'd0;
        end else begin
            if (fetch_done) begin
                ir <= fif.imem_rdata;
            end
            if (retire) begin
                inst_count <= inst_count + 32'd1;
                if (!ir_syscall) begin
                    pc_q <= next_pc;
                end
            end
        end
    end

    assign fif.imem_addr   = pc_q;
    assign fif.pc          = pc_q;
    assign fif.pc_plus4    = pc_plus4;
    assign fif.inst_word   = ir;
    assign fif.inst_opcode = ir[31:26];
    assign fif.inst_func   = ir[5:0];

endmodule
